// File: rtl/synth_multi_timer.sv
// synth_multi_timer
//   A bank of NUM_CH independent down-counting timers. Each channel has its own
//   prescaler and reload period. Each channel also has status flags, an
//   interrupt enable and a snapshot register. All of these sit behind a simple
//   word-addressed register slave.
//
// Parameters
//   NUM_CH       number of timer channels (1..8)
//   CNT_W        counter / period width in bits (16..32)
//   RESET_PERIOD reset value of every period register and counter
//
// Ports
//   clk        single clock for all logic
//   reset_n    asynchronous active-low reset
//   address    word address {channel, reg[1:0]}; reg 0 STATUS, 1 CONTROL,
//              2 PERIOD, 3 SNAP
//   chipselect slave select, qualifies write_n
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   read data, registered one cycle after address
//   irq        per-channel interrupt (TO & ITO)
//   irq_any    OR of irq
module synth_multi_timer #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h0001387F
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(NUM_CH)+1:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic [NUM_CH-1:0]          irq,
  output logic                       irq_any
);

  localparam int ADDR_W = $clog2(NUM_CH) + 2;
  localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  logic [CNT_W-1:0]  r_cnt       [NUM_CH];
  logic [CNT_W-1:0]  r_period    [NUM_CH];
  logic [CNT_W-1:0]  r_snap      [NUM_CH];
  logic [7:0]        r_presc     [NUM_CH];
  logic [7:0]        r_presc_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_to;
  logic [NUM_CH-1:0] r_ovr;
  logic [NUM_CH-1:0] r_ito;
  logic [NUM_CH-1:0] r_cont;
  logic [31:0]       r_readdata;

  logic [ADDR_W-1:0] w_ch;
  logic [1:0]        w_reg;
  logic              w_wr;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_tmo;
  logic [31:0]       w_rd;
  logic              w_unused;

  // Upper address bits select the channel; out-of-range channels match no
  // select line, so their writes vanish and their reads fall through to 0.
  assign w_ch     = address >> 2;
  assign w_reg    = address[1:0];
  assign w_wr     = chipselect & ~write_n;
  assign w_unused = ^{writedata[31:16], writedata[7:4]};

  always_comb begin
    w_sel  = '0;
    w_tick = '0;
    w_tmo  = '0;
    w_rd   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel[i]  = w_wr && (w_ch == ADDR_W'(i));
      w_tick[i] = r_run[i] && (r_presc_cnt[i] == r_presc[i]);
      w_tmo[i]  = w_tick[i] && (r_cnt[i] == '0);
      if (w_ch == ADDR_W'(i)) begin
        case (w_reg)
          REG_STATUS:  w_rd = {29'b0, r_ovr[i], r_run[i], r_to[i]};
          REG_CONTROL: w_rd = {16'b0, r_presc[i], 6'b0, r_cont[i], r_ito[i]};
          REG_PERIOD:  w_rd = 32'(r_period[i]);
          default:     w_rd = 32'(r_snap[i]);
        endcase
      end
    end
  end

  // Later assignments in each channel body override earlier ones: a register
  // write beats the count update, and START beats a one-shot RUN clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]       <= RST_CNT;
        r_period[i]    <= RST_CNT;
        r_snap[i]      <= '0;
        r_presc[i]     <= '0;
        r_presc_cnt[i] <= '0;
      end
      r_run      <= '0;
      r_to       <= '0;
      r_ovr      <= '0;
      r_ito      <= '0;
      r_cont     <= '0;
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd;
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_run[i]) begin
          r_presc_cnt[i] <= w_tick[i] ? 8'd0 : r_presc_cnt[i] + 8'd1;
        end
        if (w_tick[i]) begin
          if (w_tmo[i]) begin
            r_cnt[i] <= r_period[i];
            if (!r_cont[i]) r_run[i] <= 1'b0;
          end else begin
            r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          end
        end

        // A timeout in the same cycle as a STATUS write keeps TO set and
        // leaves OVR alone.
        if (w_sel[i] && w_reg == REG_STATUS) begin
          r_to[i] <= w_tmo[i];
          if (!w_tmo[i]) r_ovr[i] <= 1'b0;
        end else if (w_tmo[i]) begin
          r_to[i] <= 1'b1;
          if (r_to[i]) r_ovr[i] <= 1'b1;
        end

        if (w_sel[i] && w_reg == REG_CONTROL) begin
          r_ito[i]   <= writedata[0];
          r_cont[i]  <= writedata[1];
          r_presc[i] <= writedata[15:8];
          if (writedata[2]) begin
            r_run[i]       <= 1'b1;
            r_presc_cnt[i] <= '0;
          end else if (writedata[3]) begin
            r_run[i] <= 1'b0;
          end
        end

        if (w_sel[i] && w_reg == REG_PERIOD) begin
          r_period[i]    <= writedata[CNT_W-1:0];
          r_cnt[i]       <= writedata[CNT_W-1:0];
          r_run[i]       <= 1'b0;
          r_presc_cnt[i] <= '0;
        end

        if (w_sel[i] && w_reg == REG_SNAP) begin
          r_snap[i] <= r_cnt[i];
        end
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_to & r_ito;
  assign irq_any  = |irq;

endmodule

// File: doc/synth_multi_timer.md
SYNTH_MULTI_TIMER -- requirements
Module: synth_multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/period width in bits (16..32).
REQ-003 SHALL have parameter RESET_PERIOD, default 32'h0001387F, reset value of every period register and counter (truncated to CNT_W).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  clog2(NUM_CH)+2  word address {channel, reg[1:0]}.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  registered read data.
REQ-011 SHALL have port irq  output  NUM_CH  per-channel interrupt.
REQ-012 SHALL have port irq_any  output  1  OR of irq.

Function
REQ-013 SHALL map per channel: reg0 STATUS, reg1 CONTROL, reg2 PERIOD, reg3 SNAP; reads of channels >= NUM_CH SHALL return 0 and writes to them SHALL be ignored.
REQ-014 STATUS SHALL read {29'b0, OVR, RUN, TO}; any write to STATUS SHALL clear TO and OVR.
REQ-015 CONTROL SHALL store ITO=bit0, CONT=bit1, PRESC=bits[15:8]; bit2 START and bit3 STOP SHALL be write-only strobes that read back 0.
REQ-016 Each channel SHALL have a prescaler counting 0..PRESC; a tick SHALL occur in the cycle the prescaler equals PRESC while RUN=1, after which it SHALL return to 0.
REQ-017 On a tick with counter != 0, counter SHALL decrement by 1.
REQ-018 On a tick with counter == 0, counter SHALL load PERIOD, a timeout event SHALL fire, and RUN SHALL clear if CONT=0.
REQ-019 A timeout event SHALL set TO; if TO is already 1 it SHALL also set OVR.
REQ-020 A STATUS write coinciding with a timeout event SHALL leave TO=1 and OVR unchanged (event wins).
REQ-021 A PERIOD write SHALL load PERIOD and counter with writedata[CNT_W-1:0], clear RUN and clear the prescaler on the next edge.
REQ-022 A START strobe SHALL set RUN and clear the prescaler; START and STOP together SHALL set RUN (START wins).
REQ-023 A STOP strobe alone SHALL clear RUN; counter and prescaler SHALL hold while RUN=0.
REQ-024 A SNAP write SHALL copy the current counter into the snapshot register; a SNAP read SHALL return it zero-extended.
REQ-025 PERIOD reads SHALL return PERIOD zero-extended to 32 bits.
REQ-026 readdata SHALL be registered one cycle after the address is presented, independent of chipselect.
REQ-027 irq[n] SHALL equal TO[n] AND ITO[n], combinationally from registers; irq_any SHALL be their OR.
REQ-028 PERIOD=0 with CONT=1 SHALL produce a timeout on every tick.
REQ-029 Channels SHALL be fully independent; simultaneous timeouts on multiple channels SHALL all be recorded.

Reset
REQ-030 On reset_n low, asynchronously: counters and PERIOD = RESET_PERIOD, snapshot = 0, prescalers = 0, RUN/TO/OVR = 0, CONTROL = 0, readdata = 0, irq = 0.
REQ-031 Reset asserted mid-count SHALL abort the count; counting SHALL not resume until a START strobe.

Verification
REQ-032 ch0 PERIOD=3, CONTROL=0x07 (ITO,CONT,START), PRESC=0 -> timeouts every 4 cycles, TO=1 and irq[0]=1 one cycle after counter reaches 0.
REQ-033 ch1 PERIOD=2, CONTROL=0x0104 (one-shot, PRESC=1) -> counter decrements every 2 cycles, single timeout after 6 cycles, RUN=0, counter=2.
REQ-034 ch2 CONT=1, TO left uncleared across two timeouts -> STATUS reads 0x7; STATUS write -> 0x2; STATUS write on timeout cycle -> TO stays 1.
REQ-035 ch0 running from PERIOD=100; write SNAP after 10 ticks -> SNAP reads 90; PERIOD write 50 -> RUN=0, counter=50.
REQ-036 CONTROL write 0x0C -> RUN=1; reset_n pulsed mid-count -> all registers at reset values, irq=0, readdata=0.
REQ-037 NUM_CH=3: read/write address channel 3 -> readdata 0, no state change in channels 0..2.
